time_load_ctrl: RTL and testbench

User-facing time-set controller that drives the parallel-load side of the clock's hour (0-23) and minute (0-59) counters. It captures the running time, lets the user edit hours then minutes with Inc/Dec buttons (with auto-repeat), and commits the result with a single-cycle load strobe. While editing, it freezes counting and drives a blink indicator for the display.

---
 rtl/time_load_ctrl.sv | 175 +++++++++++++++++
 tb/tb_time_load_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_load_ctrl.sv
// Time-set controller: captures the live hour/minute, edits them with Inc/Dec
// (with auto-repeat), and commits them to the counters with a one-cycle LD strobe.
module time_load_ctrl #(
  parameter int HOUR_MAX    = 23,
  parameter int MIN_MAX     = 59,
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 4
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       Set_btn,
  input  logic       Inc_btn,
  input  logic       Dec_btn,
  input  logic [4:0] Cur_hour,
  input  logic [5:0] Cur_min,
  output logic [4:0] Hour_out,
  output logic [5:0] Min_out,
  output logic       LD,
  output logic       Cnt_en,
  output logic [1:0] Edit_fld,
  output logic       Blink
);

  // state    | meaning
  // IDLE     | counters running, staged values held on the load bus
  // EDIT_HR  | counting frozen, Inc/Dec step the hour
  // EDIT_MIN | counting frozen, Inc/Dec step the minute
  // LOAD     | one cycle: LD pulses with counting re-enabled
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EDIT_HR  = 2'b01,
    EDIT_MIN = 2'b10,
    LOAD     = 2'b11
  } state_t;

  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DLY_LD  = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] RATE_LD = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] CNT_TC  = RW'(1);
  localparam logic [4:0]    HMAX    = 5'(HOUR_MAX);
  localparam logic [5:0]    MMAX    = 6'(MIN_MAX);

  state_t        state, state_nxt;
  logic [2:0]    btn_s1, btn_s2, btn_prev;
  logic [2:0]    btn_edge;
  logic          set_edge, inc_edge, dec_edge, inc_held, dec_held;
  logic [RW-1:0] inc_cnt, dec_cnt, inc_cnt_nxt, dec_cnt_nxt;
  logic          editing, state_chg, inc_fire, dec_fire;
  logic          inc_req, dec_req, step_up, step_dn;
  logic [4:0]    hour_q, hour_nxt;
  logic [5:0]    min_q, min_nxt;
  logic          blink_q, blink_nxt;
  logic          edit_nxt;

  // Bit order in the button vectors: {Dec, Inc, Set}.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
    end else begin
      btn_s1   <= {Dec_btn, Inc_btn, Set_btn};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign btn_edge = btn_s2 & ~btn_prev;
  assign set_edge = btn_edge[0];
  assign inc_edge = btn_edge[1];
  assign dec_edge = btn_edge[2];
  assign inc_held = btn_s2[1];
  assign dec_held = btn_s2[2];

  assign editing   = (state == EDIT_HR) || (state == EDIT_MIN);
  assign state_chg = (state_nxt != state);

  // Hold timers count down from the repeat delay; reaching 1 on a Tick fires
  // a step and reloads the repeat rate. Any restart condition reloads the delay.
  function automatic logic [RW-1:0] hold_nxt(input logic [RW-1:0] cnt,
                                             input logic held,
                                             input logic restart,
                                             input logic tick);
    logic [RW-1:0] n;
    n = cnt;
    if (restart || !held)
      n = DLY_LD;
    else if (tick)
      n = (cnt == CNT_TC) ? RATE_LD : cnt - CNT_TC;
    return n;
  endfunction

  assign inc_fire = editing && inc_held && !inc_edge && Tick && (inc_cnt == CNT_TC);
  assign dec_fire = editing && dec_held && !dec_edge && Tick && (dec_cnt == CNT_TC);

  assign inc_cnt_nxt = hold_nxt(inc_cnt, inc_held, !editing || state_chg || inc_edge, Tick);
  assign dec_cnt_nxt = hold_nxt(dec_cnt, dec_held, !editing || state_chg || dec_edge, Tick);

  // Repeat is suppressed while the opposite button is also held.
  assign inc_req = inc_edge || (inc_fire && !dec_held);
  assign dec_req = dec_edge || (dec_fire && !inc_held);
  assign step_up = inc_req && !dec_req;
  assign step_dn = dec_req && !inc_req;

  always_comb begin
    state_nxt = state;
    hour_nxt  = hour_q;
    min_nxt   = min_q;
    case (state)
      IDLE: begin
        if (set_edge) begin
          hour_nxt  = (Cur_hour > HMAX) ? 5'd0 : Cur_hour;
          min_nxt   = (Cur_min > MMAX) ? 6'd0 : Cur_min;
          state_nxt = EDIT_HR;
        end
      end
      EDIT_HR: begin
        if (set_edge)
          state_nxt = EDIT_MIN;
        else if (step_up)
          hour_nxt = (hour_q >= HMAX) ? 5'd0 : hour_q + 5'd1;
        else if (step_dn)
          hour_nxt = (hour_q == 5'd0) ? HMAX : hour_q - 5'd1;
      end
      EDIT_MIN: begin
        if (set_edge)
          state_nxt = LOAD;
        else if (step_up)
          min_nxt = (min_q >= MMAX) ? 6'd0 : min_q + 6'd1;
        else if (step_dn)
          min_nxt = (min_q == 6'd0) ? MMAX : min_q - 6'd1;
      end
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign edit_nxt = (state_nxt == EDIT_HR) || (state_nxt == EDIT_MIN);

  always_comb begin
    blink_nxt = blink_q;
    if (!edit_nxt || state_chg)
      blink_nxt = 1'b0;
    else if (Tick)
      blink_nxt = ~blink_q;
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state   <= IDLE;
      hour_q  <= '0;
      min_q   <= '0;
      blink_q <= 1'b0;
      inc_cnt <= DLY_LD;
      dec_cnt <= DLY_LD;
    end else begin
      state   <= state_nxt;
      hour_q  <= hour_nxt;
      min_q   <= min_nxt;
      blink_q <= blink_nxt;
      inc_cnt <= inc_cnt_nxt;
      dec_cnt <= dec_cnt_nxt;
    end
  end

  assign Hour_out = hour_q;
  assign Min_out  = min_q;
  assign Edit_fld = state;
  assign LD       = (state == LOAD);
  assign Cnt_en   = !editing;
  assign Blink    = blink_q;

endmodule

// File: tb/tb_time_load_ctrl.sv
// Directed bench for time_load_ctrl: commits are scoreboarded against the LD
// strobe; intermediate field values, latency, repeat and reset are spot-checked.
module tb_time_load_ctrl;

  logic       Clk, Clr, Tick, Set_btn, Inc_btn, Dec_btn;
  logic [4:0] Cur_hour, Hour_out;
  logic [5:0] Cur_min, Min_out;
  logic       LD, Cnt_en, Blink;
  logic [1:0] Edit_fld;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
  } ld_t;

  ld_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  ld_seen     = 0;

  time_load_ctrl #(
    .HOUR_MAX(23), .MIN_MAX(59), .REPEAT_DLY(8), .REPEAT_RATE(4)
  ) dut (
    .Clk(Clk), .Clr(Clr), .Tick(Tick),
    .Set_btn(Set_btn), .Inc_btn(Inc_btn), .Dec_btn(Dec_btn),
    .Cur_hour(Cur_hour), .Cur_min(Cur_min),
    .Hour_out(Hour_out), .Min_out(Min_out), .LD(LD), .Cnt_en(Cnt_en),
    .Edit_fld(Edit_fld), .Blink(Blink)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every LD strobe must match the next queued commit.
  always @(negedge Clk) begin
    if (Clr && LD) begin
      ld_seen++;
      if (exp_q.size() == 0) begin
        chk("ld_unexpected", 1, 0);
      end else begin
        ld_t e;
        e = exp_q.pop_front();
        chk("ld_hour", int'(Hour_out), int'(e.h));
        chk("ld_min", int'(Min_out), int'(e.m));
        chk("ld_cnt_en", int'(Cnt_en), 1);
        chk("ld_fld", int'(Edit_fld), 3);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // m = {Dec, Inc, Set}; held long enough for the 3-edge latency, then released.
  task automatic press(input logic [2:0] m);
    @(negedge Clk);
    Set_btn = m[0]; Inc_btn = m[1]; Dec_btn = m[2];
    cyc(3);
    Set_btn = 1'b0; Inc_btn = 1'b0; Dec_btn = 1'b0;
    cyc(4);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clk);
      Tick = 1'b1;
      @(negedge Clk);
      Tick = 1'b0;
    end
  endtask

  task automatic push(input int h, input int m);
    ld_t e;
    e.h = 5'(h);
    e.m = 6'(m);
    exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Clr = 1'b0; Tick = 1'b0;
    Set_btn = 1'b0; Inc_btn = 1'b0; Dec_btn = 1'b0;
    Cur_hour = 5'd14; Cur_min = 6'd5;
    cyc(2);
    chk("rst_hour", int'(Hour_out), 0);
    chk("rst_min", int'(Min_out), 0);
    chk("rst_ld", int'(LD), 0);
    chk("rst_cnt_en", int'(Cnt_en), 1);
    chk("rst_fld", int'(Edit_fld), 0);
    chk("rst_blink", int'(Blink), 0);
    Clr = 1'b1;
    cyc(3);

    // Capture 14:05, Inc x2, Set, Dec, commit 16:04
    press(3'b001);
    chk("cap_hour", int'(Hour_out), 14);
    chk("cap_min", int'(Min_out), 5);
    chk("cap_fld", int'(Edit_fld), 1);
    chk("cap_cnt_en", int'(Cnt_en), 0);
    chk("cap_blink", int'(Blink), 0);
    press(3'b010);
    press(3'b010);
    chk("inc2_hour", int'(Hour_out), 16);
    press(3'b001);
    chk("min_fld", int'(Edit_fld), 2);
    chk("min_cnt_en", int'(Cnt_en), 0);
    press(3'b100);
    chk("dec_min", int'(Min_out), 4);
    push(16, 4);
    press(3'b001);
    chk("post_ld_fld", int'(Edit_fld), 0);
    chk("post_ld_cnt_en", int'(Cnt_en), 1);
    chk("post_ld_hour", int'(Hour_out), 16);

    // Wraps, latency, conflicting edges
    Cur_hour = 5'd23; Cur_min = 6'd59;
    press(3'b001);
    chk("wrap_cap_hour", int'(Hour_out), 23);
    press(3'b010);
    chk("wrap_hour_inc", int'(Hour_out), 0);
    press(3'b100);
    chk("wrap_hour_dec", int'(Hour_out), 23);
    press(3'b001);
    press(3'b010);
    chk("wrap_min_inc", int'(Min_out), 0);
    press(3'b100);
    chk("wrap_min_dec", int'(Min_out), 59);
    @(negedge Clk);
    Inc_btn = 1'b1;
    @(negedge Clk);
    chk("lat_edge1", int'(Min_out), 59);
    @(negedge Clk);
    chk("lat_edge2", int'(Min_out), 59);
    @(negedge Clk);
    chk("lat_edge3", int'(Min_out), 0);
    Inc_btn = 1'b0;
    cyc(4);
    press(3'b110);
    chk("incdec_min", int'(Min_out), 0);
    chk("incdec_fld", int'(Edit_fld), 2);
    push(23, 0);
    press(3'b011);
    chk("setinc_fld", int'(Edit_fld), 0);
    chk("setinc_min", int'(Min_out), 0);

    // Auto-repeat from hour 10
    Cur_hour = 5'd10; Cur_min = 6'd30;
    press(3'b001);
    chk("rpt_cap", int'(Hour_out), 10);
    @(negedge Clk);
    Inc_btn = 1'b1;
    cyc(3);
    chk("rpt_edge", int'(Hour_out), 11);
    tick(1);
    chk("rpt_blink1", int'(Blink), 1);
    tick(6);
    chk("rpt_tick7", int'(Hour_out), 11);
    tick(1);
    chk("rpt_tick8", int'(Hour_out), 12);
    tick(4);
    chk("rpt_tick12", int'(Hour_out), 13);
    tick(4);
    chk("rpt_tick16", int'(Hour_out), 14);
    chk("rpt_blink16", int'(Blink), 0);
    Inc_btn = 1'b0;
    cyc(4);
    @(negedge Clk);
    Inc_btn = 1'b1;
    cyc(3);
    chk("rpt2_edge", int'(Hour_out), 15);
    tick(7);
    chk("rpt2_tick7", int'(Hour_out), 15);
    tick(1);
    chk("rpt2_tick8", int'(Hour_out), 16);
    Inc_btn = 1'b0;
    cyc(4);
    press(3'b001);
    chk("rpt_min_blink", int'(Blink), 0);
    push(16, 30);
    press(3'b001);

    // Idle ignores Inc, clamp on capture, async clear mid-edit
    Cur_hour = 5'd27; Cur_min = 6'd37;
    press(3'b010);
    chk("idle_inc_hour", int'(Hour_out), 16);
    chk("idle_fld", int'(Edit_fld), 0);
    tick(1);
    chk("idle_blink", int'(Blink), 0);
    press(3'b001);
    chk("clamp_hour", int'(Hour_out), 0);
    chk("clamp_min", int'(Min_out), 37);
    press(3'b001);
    chk("clr_pre_fld", int'(Edit_fld), 2);
    chk("clr_pre_min", int'(Min_out), 37);
    @(negedge Clk);
    #2 Clr = 1'b0;
    #1;
    chk("clr_min", int'(Min_out), 0);
    chk("clr_hour", int'(Hour_out), 0);
    chk("clr_fld", int'(Edit_fld), 0);
    chk("clr_cnt_en", int'(Cnt_en), 1);
    chk("clr_ld", int'(LD), 0);
    chk("clr_blink", int'(Blink), 0);
    cyc(2);
    Clr = 1'b1;
    cyc(6);
    chk("clr_after_fld", int'(Edit_fld), 0);

    chk("ld_count", ld_seen, 3);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
